memory_port_arbiter: RTL and testbench

Sequencer that lets the core's instruction-fetch port and data port share one single-port synchronous-read Memory instance. It sits between Grande_Risco5 and a unified instruction/data memory and generates `instruction_response` and `data_memory_response`. Simultaneous requests are resolved round-robin, and every access uses a fixed access/response sequence.

---
 rtl/memory_arbiter_pkg.sv | 24 ++
 rtl/rr_arbiter_2.sv | 27 ++
 rtl/memory_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_memory_port_arbiter.sv | 508 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM states, requester identity and access type.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

  typedef enum logic {
    ReqInst = 1'b0,
    ReqData = 1'b1
  } req_e;

  typedef enum logic {
    OpRead  = 1'b0,
    OpWrite = 1'b1
  } op_e;

  // Bit positions of each requester inside the request/mask vectors.
  localparam int unsigned InstIdx = 0;
  localparam int unsigned DataIdx = 1;

endpackage

// File: rtl/rr_arbiter_2.sv
// Combinational two-way round-robin picker; mask removes a requester from consideration.
module rr_arbiter_2
  import memory_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic [1:0] mask_i,
  input  req_e       last_grant_i,
  output logic       grant_valid_o,
  output req_e       grant_id_o
);

  logic [1:0] req_m;

  assign req_m = req_i & ~mask_i;

  always_comb begin
    grant_valid_o = |req_m;
    grant_id_o    = ReqInst;
    if (req_m[InstIdx] && req_m[DataIdx]) begin
      // Tie goes to whoever was not granted last.
      grant_id_o = (last_grant_i == ReqInst) ? ReqData : ReqInst;
    end else if (req_m[DataIdx]) begin
      grant_id_o = ReqData;
    end
  end

endmodule

// File: rtl/memory_port_arbiter.sv
// Shares one synchronous-read memory between the fetch port and the data port using a
// fixed IDLE -> ACCESS -> RESP sequence with round-robin arbitration.
module memory_port_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inst_request,
  input  logic [ADDR_WIDTH-1:0] inst_address,
  output logic [DATA_WIDTH-1:0] inst_read_data,
  output logic                  inst_response,
  input  logic                  data_read,
  input  logic                  data_write,
  input  logic [ADDR_WIDTH-1:0] data_address,
  input  logic [DATA_WIDTH-1:0] data_write_data,
  output logic [DATA_WIDTH-1:0] data_read_data,
  output logic                  data_response,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  state_e                state_q, state_d;
  req_e                  owner_q, owner_d;
  req_e                  last_grant_q, last_grant_d;
  op_e                   op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic [1:0] req;
  logic [1:0] mask;
  logic       grant_valid;
  req_e       grant_id;

  assign req[InstIdx] = inst_request;
  assign req[DataIdx] = data_read | data_write;

  // In RESP the owner's request is still high, so it must not be re-granted.
  always_comb begin
    mask = 2'b00;
    if (state_q == StResp) begin
      mask[InstIdx] = (owner_q == ReqInst);
      mask[DataIdx] = (owner_q == ReqData);
    end
  end

  rr_arbiter_2 u_rr_arbiter_2 (
    .req_i         (req),
    .mask_i        (mask),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (grant_valid),
    .grant_id_o    (grant_id)
  );

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_grant_d   = last_grant_q;
    op_d           = op_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    mem_address    = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_write_data = '0;
    inst_response  = 1'b0;
    inst_read_data = '0;
    data_response  = 1'b0;
    data_read_data = '0;

    unique case (state_q)
      StIdle: begin
        if (grant_valid) begin
          state_d = StAccess;
        end
      end
      StAccess: begin
        mem_address    = addr_q;
        mem_read       = (op_q == OpRead);
        mem_write      = (op_q == OpWrite);
        mem_write_data = wdata_q;
        state_d        = StResp;
      end
      StResp: begin
        if (owner_q == ReqInst) begin
          inst_response  = 1'b1;
          inst_read_data = mem_read_data;
        end else begin
          data_response  = 1'b1;
          data_read_data = (op_q == OpRead) ? mem_read_data : '0;
        end
        state_d = grant_valid ? StAccess : StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Capture the winner's bus at grant so later input changes cannot disturb the access.
    if (grant_valid && (state_q == StIdle || state_q == StResp)) begin
      owner_d      = grant_id;
      last_grant_d = grant_id;
      if (grant_id == ReqInst) begin
        addr_d  = inst_address;
        op_d    = OpRead;
        wdata_d = '0;
      end else begin
        addr_d  = data_address;
        op_d    = data_write ? OpWrite : OpRead;
        wdata_d = data_write ? data_write_data : '0;
      end
    end

    // Reset kills the in-flight access immediately, including an ACCESS-cycle store.
    if (reset) begin
      mem_address    = '0;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      mem_write_data = '0;
      inst_response  = 1'b0;
      inst_read_data = '0;
      data_response  = 1'b0;
      data_read_data = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      owner_q      <= ReqInst;
      last_grant_q <= ReqData;
      op_q         <= OpRead;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  a_mem_onehot : assert property (@(posedge clk) disable iff (reset) !(mem_read && mem_write));
  a_resp_single : assert property (@(posedge clk) disable iff (reset)
                                   !(inst_response && data_response));

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Self-checking bench for memory_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of arbitration order and memory contents.
module tb_memory_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam bit SrvInst = 1'b0;
  localparam bit SrvData = 1'b1;

  logic          clk = 1'b0;
  logic          reset;
  logic          inst_request;
  logic [AW-1:0] inst_address;
  logic [DW-1:0] inst_read_data;
  logic          inst_response;
  logic          data_read;
  logic          data_write;
  logic [AW-1:0] data_address;
  logic [DW-1:0] data_write_data;
  logic [DW-1:0] data_read_data;
  logic          data_response;
  logic [AW-1:0] mem_address;
  logic          mem_read;
  logic          mem_write;
  logic [DW-1:0] mem_write_data;
  logic [DW-1:0] mem_read_data;

  int checks = 0;
  int failures = 0;
  logic [31:0] shadow [256];
  bit last_served;

  memory_port_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .inst_request    (inst_request),
    .inst_address    (inst_address),
    .inst_read_data  (inst_read_data),
    .inst_response   (inst_response),
    .data_read       (data_read),
    .data_write      (data_write),
    .data_address    (data_address),
    .data_write_data (data_write_data),
    .data_read_data  (data_read_data),
    .data_response   (data_response),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_write_data  (mem_write_data),
    .mem_read_data   (mem_read_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    return 32'hC0DE_0000 + (32'(i) * 32'h0000_0107);
  endfunction

  // Synchronous-read memory; read data is garbage unless a read happened last cycle.
  logic [31:0] mem_arr [256];
  logic [31:0] mem_rdata_q;
  logic        mem_ready = 1'b0;
  assign mem_read_data = mem_rdata_q;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (mem_write) begin
      mem_arr[mem_address[9:2]] <= mem_write_data;
    end
    if (mem_read) mem_rdata_q <= mem_arr[mem_address[9:2]];
    else          mem_rdata_q <= 32'hBAD0_0BAD;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    inst_request    = 1'b0;
    inst_address    = '0;
    data_read       = 1'b0;
    data_write      = 1'b0;
    data_address    = '0;
    data_write_data = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (2) step();
    reset = 1'b0;
    last_served = SrvData;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    inst_request    = 1'b1;
    inst_address    = 32'h44;
    data_write      = 1'b1;
    data_address    = 32'h48;
    data_write_data = 32'h1111_2222;
    repeat (3) begin
      step();
      @(negedge clk);
      checks++;
      if ({mem_read, mem_write, inst_response, data_response} !== 4'b0 || mem_address !== '0 ||
          mem_write_data !== '0 || inst_read_data !== '0 || data_read_data !== '0) begin
        failures++;
        $display("FAIL reset_outputs: rd=%b wr=%b iresp=%b dresp=%b addr=%h wd=%h ird=%h drd=%h, want all 0",
                 mem_read, mem_write, inst_response, data_response, mem_address,
                 mem_write_data, inst_read_data, data_read_data);
      end
    end
    step();
    reset = 1'b0;
    clear_inputs();
    @(negedge clk);
    checks++;
    if ({mem_read, mem_write, inst_response, data_response} !== 4'b0) begin
      failures++;
      $display("FAIL reset_idle: rd=%b wr=%b iresp=%b dresp=%b, want 0000",
               mem_read, mem_write, inst_response, data_response);
    end
    step();
  endtask

  task automatic test_single_fetch();
    apply_reset();
    inst_request = 1'b1;
    inst_address = 32'h10;
    @(negedge clk);
    checks++;
    if (mem_read !== 1'b0) begin
      failures++;
      $display("FAIL fetch_cycle0: mem_read=%b, want 0", mem_read);
    end
    step();
    @(negedge clk);
    checks++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 32'h10) begin
      failures++;
      $display("FAIL fetch_access: rd=%b wr=%b addr=%h, want 1 0 00000010",
               mem_read, mem_write, mem_address);
    end
    step();
    @(negedge clk);
    checks++;
    if (inst_response !== 1'b1 || inst_read_data !== shadow[4] || data_response !== 1'b0) begin
      failures++;
      $display("FAIL fetch_resp: iresp=%b data=%h dresp=%b, want 1 %h 0",
               inst_response, inst_read_data, data_response, shadow[4]);
    end
    step();
    inst_request = 1'b0;
    @(negedge clk);
    checks++;
    if (inst_response !== 1'b0 || inst_read_data !== '0) begin
      failures++;
      $display("FAIL fetch_after: iresp=%b data=%h, want 0 0", inst_response, inst_read_data);
    end
    step();
  endtask

  task automatic test_simultaneous();
    apply_reset();
    inst_request = 1'b1;
    inst_address = 32'h0;
    data_read    = 1'b1;
    data_address = 32'h40;
    step();
    @(negedge clk);
    checks++;
    if (mem_read !== 1'b1 || mem_address !== 32'h0) begin
      failures++;
      $display("FAIL sim_first_access: rd=%b addr=%h, want 1 00000000", mem_read, mem_address);
    end
    step();
    @(negedge clk);
    checks++;
    if (inst_response !== 1'b1 || data_response !== 1'b0 || inst_read_data !== shadow[0]) begin
      failures++;
      $display("FAIL sim_inst_resp: iresp=%b dresp=%b data=%h, want 1 0 %h",
               inst_response, data_response, inst_read_data, shadow[0]);
    end
    step();
    inst_request = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_read !== 1'b1 || mem_address !== 32'h40 || inst_response !== 1'b0) begin
      failures++;
      $display("FAIL sim_data_access: rd=%b addr=%h iresp=%b, want 1 00000040 0",
               mem_read, mem_address, inst_response);
    end
    step();
    @(negedge clk);
    checks++;
    if (data_response !== 1'b1 || data_read_data !== shadow[16]) begin
      failures++;
      $display("FAIL sim_data_resp: dresp=%b data=%h, want 1 %h",
               data_response, data_read_data, shadow[16]);
    end
    step();
    data_read = 1'b0;
    step();
  endtask

  task automatic test_store_load();
    data_write      = 1'b1;
    data_address    = 32'h80;
    data_write_data = 32'hDEAD_BEEF;
    step();
    @(negedge clk);
    checks++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== 32'h80 ||
        mem_write_data !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL store_access: wr=%b rd=%b addr=%h wd=%h, want 1 0 00000080 deadbeef",
               mem_write, mem_read, mem_address, mem_write_data);
    end
    step();
    @(negedge clk);
    checks++;
    if (data_response !== 1'b1 || data_read_data !== '0) begin
      failures++;
      $display("FAIL store_resp: dresp=%b data=%h, want 1 0", data_response, data_read_data);
    end
    shadow[32] = 32'hDEAD_BEEF;
    step();
    data_write      = 1'b0;
    data_write_data = '0;
    data_read       = 1'b1;
    repeat (2) step();
    @(negedge clk);
    checks++;
    if (data_response !== 1'b1 || data_read_data !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL store_readback: dresp=%b data=%h, want 1 deadbeef",
               data_response, data_read_data);
    end
    step();
    data_read = 1'b0;
    step();
  endtask

  task automatic test_alternate();
    int n = 0;
    int c = 0;
    bit seq [8];
    int at [8];
    bit bump_i;
    bit bump_d;
    apply_reset();
    inst_request = 1'b1;
    inst_address = 32'h100;
    data_read    = 1'b1;
    data_address = 32'h300;
    while (n < 8 && c < 40) begin
      bump_i = 1'b0;
      bump_d = 1'b0;
      @(negedge clk);
      if (inst_response && n < 8) begin
        checks++;
        if (inst_read_data !== shadow[inst_address[9:2]]) begin
          failures++;
          $display("FAIL alt_inst_data: got %h, want %h", inst_read_data,
                   shadow[inst_address[9:2]]);
        end
        seq[n] = SrvInst;
        at[n]  = c;
        n++;
        bump_i = 1'b1;
      end
      if (data_response && n < 8) begin
        checks++;
        if (data_read_data !== shadow[data_address[9:2]]) begin
          failures++;
          $display("FAIL alt_data_data: got %h, want %h", data_read_data,
                   shadow[data_address[9:2]]);
        end
        seq[n] = SrvData;
        at[n]  = c;
        n++;
        bump_d = 1'b1;
      end
      step();
      c++;
      if (bump_i) inst_address = inst_address + 32'd4;
      if (bump_d) data_address = data_address + 32'd4;
    end
    checks++;
    if (n != 8) begin
      failures++;
      $display("FAIL alt_count: got %0d responses in %0d cycles, want 8", n, c);
    end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (seq[k] !== ((k % 2 == 1) ? SrvData : SrvInst) || (k > 0 && at[k] - at[k-1] != 2)) begin
        failures++;
        $display("FAIL alt_order: response %0d from %0d at gap %0d, want %0d at gap 2",
                 k, seq[k], (k > 0) ? at[k] - at[k-1] : 0, k % 2);
      end
    end
    clear_inputs();
    repeat (3) step();
  endtask

  task automatic test_reset_during_store();
    data_write      = 1'b1;
    data_address    = 32'h80;
    data_write_data = 32'h1234_5678;
    step();
    reset      = 1'b1;
    data_write = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_write !== 1'b0 || mem_read !== 1'b0 || data_response !== 1'b0) begin
      failures++;
      $display("FAIL rst_store_access: wr=%b rd=%b dresp=%b, want 0 0 0",
               mem_write, mem_read, data_response);
    end
    step();
    reset = 1'b0;
    last_served = SrvData;
    @(negedge clk);
    checks++;
    if (data_response !== 1'b0 || mem_write !== 1'b0 || mem_read !== 1'b0) begin
      failures++;
      $display("FAIL rst_store_idle: dresp=%b wr=%b rd=%b, want 0 0 0",
               data_response, mem_write, mem_read);
    end
    step();
    data_read    = 1'b1;
    data_address = 32'h80;
    repeat (2) step();
    @(negedge clk);
    checks++;
    if (data_response !== 1'b1 || data_read_data !== shadow[32]) begin
      failures++;
      $display("FAIL rst_store_unchanged: dresp=%b data=%h, want 1 %h",
               data_response, data_read_data, shadow[32]);
    end
    step();
    data_read = 1'b0;
    step();
  endtask

  task automatic test_read_write_both();
    data_read       = 1'b1;
    data_write      = 1'b1;
    data_address    = 32'h84;
    data_write_data = 32'hCAFE_F00D;
    step();
    @(negedge clk);
    checks++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_write_data !== 32'hCAFE_F00D) begin
      failures++;
      $display("FAIL both_access: wr=%b rd=%b wd=%h, want 1 0 cafef00d",
               mem_write, mem_read, mem_write_data);
    end
    step();
    @(negedge clk);
    checks++;
    if (data_response !== 1'b1 || data_read_data !== '0) begin
      failures++;
      $display("FAIL both_resp: dresp=%b data=%h, want 1 0", data_response, data_read_data);
    end
    shadow[33] = 32'hCAFE_F00D;
    step();
    clear_inputs();
    step();
  endtask

  task automatic test_random();
    bit i_pend = 0, d_pend = 0, d_wr = 0, d_rd = 0, i_done = 0, d_done = 0;
    logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0;
    bit p_ipend = 0, p_dpend = 0, p_dwr = 0;
    logic [31:0] p_iaddr = 0, p_daddr = 0, p_dwdata = 0;
    bit acc_v = 0, acc_id = 0, served, exp_srv, allow_new;
    int i_age = 0, d_age = 0, max_age = 0, n_i = 0, n_d = 0;
    apply_reset();
    for (int cyc = 0; cyc < 460; cyc++) begin
      allow_new = (cyc < 420);
      if (i_done) begin i_pend = 0; i_done = 0; end
      if (d_done) begin d_pend = 0; d_done = 0; end
      if (!i_pend && allow_new && $urandom_range(0, 2) == 0) begin
        i_pend = 1;
        i_age  = 0;
        i_addr = 32'($urandom_range(0, 127)) << 2;
      end
      if (!d_pend && allow_new && $urandom_range(0, 2) == 0) begin
        d_pend  = 1;
        d_age   = 0;
        d_wr    = 1'($urandom_range(0, 1));
        d_rd    = 1'($urandom_range(0, 1));
        d_addr  = 32'h200 + (32'($urandom_range(0, 127)) << 2);
        d_wdata = $urandom;
      end
      inst_request    = i_pend;
      inst_address    = i_addr;
      data_write      = d_pend & d_wr;
      data_read       = d_pend & (~d_wr | d_rd);
      data_address    = d_addr;
      data_write_data = d_wdata;
      @(negedge clk);
      if (inst_response) begin
        checks++;
        n_i++;
        if (!i_pend || !acc_v || acc_id != SrvInst) begin
          failures++;
          $display("FAIL rnd_inst_resp: pend=%b prev_access=%b/%0d, want 1 1/0",
                   i_pend, acc_v, acc_id);
        end else if (inst_read_data !== shadow[i_addr[9:2]]) begin
          failures++;
          $display("FAIL rnd_inst_data: addr=%h got %h, want %h", i_addr, inst_read_data,
                   shadow[i_addr[9:2]]);
        end
        i_done = 1;
      end
      if (data_response) begin
        checks++;
        n_d++;
        if (!d_pend || !acc_v || acc_id != SrvData) begin
          failures++;
          $display("FAIL rnd_data_resp: pend=%b prev_access=%b/%0d, want 1 1/1",
                   d_pend, acc_v, acc_id);
        end else if (data_read_data !== (d_wr ? 32'h0 : shadow[d_addr[9:2]])) begin
          failures++;
          $display("FAIL rnd_data_data: addr=%h wr=%b got %h, want %h", d_addr, d_wr,
                   data_read_data, d_wr ? 32'h0 : shadow[d_addr[9:2]]);
        end
        if (d_wr) shadow[d_addr[9:2]] = d_wdata;
        d_done = 1;
      end
      if (mem_read || mem_write) begin
        served = (mem_address < 32'h200) ? SrvInst : SrvData;
        if (p_ipend && p_dpend) exp_srv = !last_served;
        else                    exp_srv = p_dpend ? SrvData : SrvInst;
        checks++;
        if (!(p_ipend || p_dpend) || served !== exp_srv) begin
          failures++;
          $display("FAIL rnd_arb: served %0d with pending i=%b d=%b last=%0d, want %0d",
                   served, p_ipend, p_dpend, last_served, exp_srv);
        end else if (served == SrvInst ?
                     (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== p_iaddr ||
                      mem_write_data !== '0) :
                     (mem_write !== p_dwr || mem_read !== !p_dwr || mem_address !== p_daddr ||
                      mem_write_data !== (p_dwr ? p_dwdata : 32'h0))) begin
          failures++;
          $display("FAIL rnd_access: id=%0d rd=%b wr=%b addr=%h wd=%h, want addr %h wr=%b wd=%h",
                   served, mem_read, mem_write, mem_address, mem_write_data,
                   served == SrvInst ? p_iaddr : p_daddr, served == SrvData && p_dwr,
                   (served == SrvData && p_dwr) ? p_dwdata : 32'h0);
        end
        last_served = served;
        acc_v  = 1;
        acc_id = served;
      end else begin
        acc_v = 0;
      end
      if (i_pend && !i_done) begin i_age++; if (i_age > max_age) max_age = i_age; end
      if (d_pend && !d_done) begin d_age++; if (d_age > max_age) max_age = d_age; end
      p_ipend  = i_pend;
      p_dpend  = d_pend;
      p_dwr    = d_wr;
      p_iaddr  = i_addr;
      p_daddr  = d_addr;
      p_dwdata = d_wdata;
      step();
    end
    checks++;
    if (max_age > 8 || (i_pend && !i_done) || (d_pend && !d_done)) begin
      failures++;
      $display("FAIL rnd_latency: max wait %0d, open i=%b d=%b, want <=8 and none open",
               max_age, i_pend && !i_done, d_pend && !d_done);
    end
    checks++;
    if (n_i == 0 || n_d == 0) begin
      failures++;
      $display("FAIL rnd_activity: inst=%0d data=%0d responses, want both nonzero", n_i, n_d);
    end
    clear_inputs();
    repeat (3) step();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_store_load();
    test_alternate();
    test_reset_during_store();
    test_read_write_both();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
